// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : single-port RAM arbiter for fetch/data with LL/SC link  |
// |               tracking and a stalled-handshake watchdog              |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int MAX_WAIT = 64,
  parameter int WORD_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam int             CW        = $clog2(MAX_WAIT);
  localparam logic [CW-1:0]  WCNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [1:0]     S_IDLE    = 2'd0;
  localparam logic [1:0]     S_DACC    = 2'd1;
  localparam logic [1:0]     S_IACC    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic              link_valid_q, link_valid_d;
  logic [WORD_W-1:0] link_addr_q, link_addr_d;

  logic w_is_sc;
  logic w_link_hit;
  logic w_pick_d;
  logic w_sc_ffail;
  logic w_wd_expire;

  assign w_is_sc     = dWEN & datomic;
  assign w_link_hit  = link_valid_q & (link_addr_q == daddr);
  // Data wins unless both ports are pending and data had the last grant.
  assign w_pick_d    = (dREN | dWEN) & ~(iREN & last_d_q);
  assign w_sc_ffail  = (state_q == S_IDLE) & w_pick_d & w_is_sc & ~w_link_hit;
  assign w_wd_expire = (wcnt_q == WCNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      last_d_q     <= 1'b0;
      wcnt_q       <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      wcnt_q       <= wcnt_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    wcnt_d       = wcnt_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    case (state_q)
      S_IDLE: begin
        wcnt_d = '0;
        if (w_sc_ffail) begin
          last_d_d = 1'b1;
        end else if (w_pick_d) begin
          state_d = S_DACC;
        end else if (iREN) begin
          state_d = S_IACC;
        end
      end
      S_DACC: begin
        if (ram_ready) begin
          state_d  = S_IDLE;
          last_d_d = 1'b1;
          if (dREN & datomic) begin
            link_valid_d = 1'b1;
            link_addr_d  = daddr;
          end else if (w_is_sc) begin
            link_valid_d = 1'b0;
          end else if (dWEN & (daddr == link_addr_q)) begin
            link_valid_d = 1'b0;
          end
        end else if (w_wd_expire) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_IACC: begin
        if (!iREN) begin
          state_d = S_IDLE;
        end else if (ram_ready) begin
          state_d  = S_IDLE;
          last_d_d = 1'b0;
        end else if (w_wd_expire) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A failing SC completes here without ever reaching the RAM.
        if (w_sc_ffail) dwait = 1'b0;
      end
      S_DACC: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ram_ready) begin
          dwait = 1'b0;
          dload = w_is_sc ? WORD_W'(1) : ramload;
        end else if (w_wd_expire) begin
          err = 1'b1;
        end
      end
      S_IACC: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_ready) begin
            iwait = 1'b0;
            iload = ramload;
          end else if (w_wd_expire) begin
            err = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : directed vector bench for mem_arbiter               |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        iren, dren, dwen, datomic, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramren, ramwen, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MAX_WAIT(4), .WORD_W(32)) dut (
    .CLK(clk), .RST(rst),
    .iREN(iren), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dren), .dWEN(dwen), .datomic(datomic), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramren), .ramWEN(ramwen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic        rst;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic        dat;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        rdy;
    logic [31:0] ramload;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_iwait;
    logic [31:0] e_iload;
    logic        e_dwait;
    logic [31:0] e_dload;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic chk, input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic da, input logic [31:0] dad,
                     input logic [31:0] ds, input logic rdy, input logic [31:0] rl,
                     input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                     input logic [31:0] e_store, input logic e_iwait, input logic [31:0] e_iload,
                     input logic e_dwait, input logic [31:0] e_dload, input logic e_err);
    vec_t v;
    v = '{chk, r, ir, ia, dr, dw, da, dad, ds, rdy, rl,
          e_ren, e_wen, e_addr, e_store, e_iwait, e_iload, e_dwait, e_dload, e_err};
    vq.push_back(v);
  endtask

  // Cycle spent in IDLE: every output sits at its quiet value.
  task automatic idle_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic da, input logic [31:0] dad, input logic [31:0] ds,
                         input logic rdy, input logic [31:0] rl);
    add(1, 0, ir, ia, dr, dw, da, dad, ds, rdy, rl, 0, 0, 0, 0, 1, 0, 1, 0, 0);
  endtask

  task automatic data_access(input logic dr, input logic dw, input logic da,
                             input logic [31:0] dad, input logic [31:0] ds,
                             input logic [31:0] rl, input logic [31:0] e_dload);
    idle_in(0, 0, dr, dw, da, dad, ds, 0, 0);
    add(1, 0, 0, 0, dr, dw, da, dad, ds, 1, rl, dr, dw, dad, ds, 1, 0, 0, e_dload, 0);
  endtask

  task automatic sc_fail(input logic [31:0] dad, input logic [31:0] ds);
    add(1, 0, 0, 0, 0, 1, 1, dad, ds, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @vec%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; iren = v.iren; iaddr = v.iaddr; dren = v.dren; dwen = v.dwen;
    datomic = v.dat; daddr = v.daddr; dstore = v.dstore; ram_ready = v.rdy;
    ramload = v.ramload;
  endtask

  task automatic check(input int i, input vec_t v);
    cmp("ramREN",   i, {31'b0, ramren}, {31'b0, v.e_ren});
    cmp("ramWEN",   i, {31'b0, ramwen}, {31'b0, v.e_wen});
    cmp("ramaddr",  i, ramaddr,         v.e_addr);
    cmp("ramstore", i, ramstore,        v.e_store);
    cmp("iwait",    i, {31'b0, iwait},  {31'b0, v.e_iwait});
    cmp("iload",    i, iload,           v.e_iload);
    cmp("dwait",    i, {31'b0, dwait},  {31'b0, v.e_dwait});
    cmp("dload",    i, dload,           v.e_dload);
    cmp("err",      i, {31'b0, err},    {31'b0, v.e_err});
  endtask

  initial begin
    int  strobes;
    int  dw_bad;
    bit  seen;
    bit  done;

    rst = 1'b1; iren = 0; dren = 0; dwen = 0; datomic = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;

    // Reset, then check the quiet state.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    idle_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Instruction fetch: grant at N+1, complete at N+2.
    idle_in(1, 'h40, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 'h40, 0, 0, 0, 0, 0, 0, 0,          1, 0, 'h40, 0, 1, 0,           1, 0, 0);
    add(1, 0, 1, 'h40, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 1, 0, 'h40, 0, 0, 'hDEADBEEF, 1, 0, 0);
    idle_in(0, 0, 0, 0, 0, 0, 0, 0, 'hDEADBEEF);

    // Continuous contention with ram_ready high: D, I, D, I ...
    for (int r = 0; r < 3; r++) begin
      idle_in(1, 'h80, 1, 0, 0, 'h200, 0, 1, 'h1234);
      add(1, 0, 1, 'h80, 1, 0, 0, 'h200, 0, 1, 'h1234, 1, 0, 'h200, 0, 1, 0, 0, 'h1234, 0);
      idle_in(1, 'h80, 1, 0, 0, 'h200, 0, 1, 'h1234);
      add(1, 0, 1, 'h80, 1, 0, 0, 'h200, 0, 1, 'h1234, 1, 0, 'h80, 0, 0, 'h1234, 1, 0, 0);
    end

    // LL, successful SC, then a repeated SC that fails in IDLE.
    data_access(1, 0, 1, 'h100, 0, 'h77, 'h77);
    data_access(0, 1, 1, 'h100, 5, 'h99, 1);
    sc_fail('h100, 5);

    // A plain store to the linked address breaks the link; a different address does not.
    data_access(1, 0, 1, 'h100, 0, 'h77, 'h77);
    data_access(0, 1, 0, 'h100, 'hAA, 0, 0);
    sc_fail('h100, 9);
    data_access(1, 0, 1, 'h100, 0, 'h66, 'h66);
    data_access(0, 1, 0, 'h104, 'hBB, 0, 0);
    data_access(0, 1, 1, 'h100, 7, 'h99, 1);
    idle_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fetch flushed in its second IACC cycle.
    idle_in(1, 'h44, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 'h44, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h44, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 1, 0, 0);
    idle_in(0, 0, 0, 0, 0, 0, 0, 1, 'h5A);

    // Reset in the middle of a data access, request held throughout.
    idle_in(0, 0, 1, 0, 0, 'h500, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 'h500, 0, 0, 0,    1, 0, 'h500, 0, 1, 0, 1, 0,     0);
    add(1, 1, 0, 0, 1, 0, 0, 'h500, 0, 0, 0,    1, 0, 'h500, 0, 1, 0, 1, 0,     0);
    idle_in(0, 0, 1, 0, 0, 'h500, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 'h500, 0, 1, 'h42, 1, 0, 'h500, 0, 1, 0, 0, 'h42, 0);
    idle_in(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      if (vq[i].chk) check(i, vq[i]);
    end

    // Watchdog: ram_ready held low, abort on the 4th strobe cycle, then re-grant.
    @(negedge clk);
    rst = 0; iren = 0; dwen = 0; datomic = 0; dren = 1; daddr = 'h300; dstore = 0;
    ram_ready = 0; ramload = 0;
    #1;
    cmp("wd_idle_ramREN", -1, {31'b0, ramren}, 0);
    strobes = 0; dw_bad = 0; seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (ramren === 1'b1) strobes++;
      if (dwait !== 1'b1) dw_bad++;
      if (err === 1'b1) seen = 1;
    end
    cmp("wd_err_seen",     -1, {31'b0, seen}, 1);
    cmp("wd_strobe_count", -1, strobes, 4);
    cmp("wd_dwait_low",    -1, dw_bad, 0);
    @(negedge clk);
    #1;
    cmp("wd_after_ramREN", -1, {31'b0, ramren}, 0);
    cmp("wd_after_err",    -1, {31'b0, err},    0);
    cmp("wd_after_dwait",  -1, {31'b0, dwait},  1);
    ram_ready = 1; ramload = 'hCAFE;
    done = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      @(negedge clk);
      #1;
      if (dwait === 1'b0) done = 1;
    end
    cmp("wd_regrant_done",  -1, {31'b0, done}, 1);
    cmp("wd_regrant_dload", -1, dload,   'hCAFE);
    cmp("wd_regrant_addr",  -1, ramaddr, 'h300);
    @(negedge clk);
    dren = 0; ram_ready = 0; ramload = 0;
    #1;
    cmp("wd_end_dwait", -1, {31'b0, dwait}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
